mips_multicycle: RTL and testbench
==================================

# mips_multicycle

Multi-cycle successor to the single-cycle MIPS top: one FSM-sequenced core that fetches and executes the team's integer MIPS subset through a single unified memory port with a ready handshake. Memory latency is variable, so slow or shared memories are supported. The block sits in place of the single-cycle top and talks to one memory model/arbiter instead of separate instruction and data memories.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- LINK_REG, 31, register written by jal
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1 during a read
- mem_ready  in  1  completes the current memory request
- mem_addr  out  32  byte address of the current request
- mem_wdata  out  32  store data; valid while mem_write=1
- mem_read  out  1  read request (fetch or lw)
- mem_write  out  1  write request (sw)
- pc_out  out  32  architectural PC register
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct

## Operation
- Supported instructions:
  - R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - I-type and jumps: addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- Register file: 32x32; $0 always reads 0 and writes to it are dropped. All registers clear on reset.
- Arithmetic: 32-bit two's complement, overflow ignored. Immediates are sign-extended.
- slt/slti: signed compare, result 0 or 1.
- Branch target: PC+4 + (sext(imm)<<2).
- Jump target: {PC+4[31:28], imm26, 2'b00}.
- FSM states and transitions:
  - FETCH: drive mem_read=1, mem_addr=PC. Stay while mem_ready=0. On mem_ready=1: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: latch A=R[rs], B=R[rt]; precompute the branch target. Then:
    - j: PC<=target, go to FETCH.
    - jal: R[LINK_REG]<=PC (already PC+4), PC<=target, go to FETCH.
    - jr: PC<=R[rs], go to FETCH.
    - illegal: pulse illegal, treat as NOP, go to FETCH.
    - all others: go to EXEC.
  - EXEC:
    - R/addi/slti: ALUOut<=result, go to WB.
    - beq: if A==B then PC<=target; go to FETCH.
    - lw/sw: ALUOut<=A+sext(imm), go to MEM.
  - MEM: mem_addr=ALUOut, held stable until mem_ready.
    - lw: mem_read=1; on ready MDR<=mem_rdata, go to WB.
    - sw: mem_write=1, mem_wdata=B; on ready go to FETCH.
  - WB: R-type writes R[rd]<=ALUOut; addi/slti write R[rt]<=ALUOut; lw writes R[rt]<=MDR. Go to FETCH.
- mem_read and mem_write are never both 1. Outside FETCH and MEM both are 0 and mem_addr is don't-care.
- Addresses are not alignment-checked; software guarantees word alignment.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, instr_done=0, illegal=0, all registers 0.
- First cycle after rst drops: mem_read=1, mem_addr=RESET_PC.
- Request outputs are registered-state decodes, stable for the whole wait. They deassert in the cycle after mem_ready is sampled high.
- Latency with zero-wait memory (ready=1 in the request's first cycle): j/jal/jr 2 cycles, beq 3, R/addi/slti 4, sw 4, lw 5. Each wait cycle adds 1.
- instr_done is high in the last state of each instruction, coincident with the state transition back to FETCH.
- A register write in WB or jal-DECODE is visible to the next instruction's DECODE.
- rst asserted mid-wait or in any state: the pending request is abandoned and the next cycle is FETCH at RESET_PC. No partial register or PC update survives.
- mem_ready asserted while no request is active is ignored.

## Test plan
- Reset and first fetch: hold rst 2 cycles with RESET_PC=0x100, then release -> mem_read=1, mem_addr=0x100, pc_out=0x100; no write before the first ready.
- ALU sequence, zero-wait: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1, each instruction 4 cycles, instr_done pulse count 4. Also addi $0,$0,7 -> $0 still reads 0.
- Memory with 3 wait states: sw $3,8($0) then lw $5,8($0) -> write of 2 to 0x8, $5=2. mem_addr and mem_wdata stay stable across waits. lw takes 5+3+3 cycles.
- Control flow: beq taken (+2) skips two instructions; beq not taken falls through. jal at 0x40 -> $31=0x44; jr $31 returns to 0x44.
- Illegal opcode 0x3F -> illegal pulses once, PC advances by 4, no register or memory change.
- Reset mid-lw wait (rst during MEM with ready=0) -> next cycle FETCH at RESET_PC, target register unchanged (0), mem_write never asserted.

Source files
------------

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS integer core.
// One FSM shares a single memory port with ready handshake for fetch and data.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          LINK_REG = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] pc_out,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
  } state_t;

  localparam logic [4:0] LINK = LINK_REG[4:0];

  state_t state, next;

  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_s, br_target, j_target;

  assign op        = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm_s     = {{16{ir[15]}}, ir[15:0]};
  assign br_target = pc + {imm_s[29:0], 2'b00};
  assign j_target  = {pc[31:28], ir[25:0], 2'b00};
  assign pc_out    = pc;

  logic is_r, f_add, f_sub, f_and, f_or, f_slt, is_jr;
  logic is_addi, is_slti, is_lw, is_sw, is_beq, is_j, is_jal;
  logic legal;

  assign is_r    = (op == 6'h00);
  assign f_add   = is_r && (funct == 6'h20);
  assign f_sub   = is_r && (funct == 6'h22);
  assign f_and   = is_r && (funct == 6'h24);
  assign f_or    = is_r && (funct == 6'h25);
  assign f_slt   = is_r && (funct == 6'h2A);
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_addi = (op == 6'h08);
  assign is_slti = (op == 6'h0A);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);

  assign legal = f_add | f_sub | f_and | f_or | f_slt | is_jr |
                 is_addi | is_slti | is_lw | is_sw | is_beq |
                 is_j | is_jal;

  logic [31:0] alu_b, alu_res;

  always_comb begin
    alu_b   = is_r ? b : imm_s;
    alu_res = a + alu_b;
    unique case (1'b1)
      f_sub:           alu_res = a - b;
      f_and:           alu_res = a & b;
      f_or:            alu_res = a | b;
      f_slt | is_slti: alu_res = {31'd0, $signed(a) < $signed(alu_b)};
      default: ;
    endcase
  end

  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  assign wb_dst  = is_r ? rd : rt;
  assign wb_data = is_lw ? mdr : alu_out;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  // Port outputs decode the registered state; reset forces them idle.
  always_comb begin
    next       = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read = 1'b1;
        mem_addr = pc;
        if (mem_ready) next = DECODE;
      end
      DECODE: begin
        if (is_j || is_jal || is_jr || !legal) begin
          next       = FETCH;
          instr_done = 1'b1;
          illegal    = !legal;
        end else begin
          next = EXEC;
        end
      end
      EXEC: begin
        if (is_beq) begin
          next       = FETCH;
          instr_done = 1'b1;
        end else if (is_lw || is_sw) begin
          next = MEM;
        end else begin
          next = WB;
        end
      end
      MEM: begin
        mem_addr = alu_out;
        if (is_lw) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          mem_wdata = b;
        end
        if (mem_ready) next = is_lw ? WB : FETCH;
        instr_done = mem_ready && is_sw;
      end
      WB: begin
        next       = FETCH;
        instr_done = 1'b1;
      end
      default: next = FETCH;
    endcase
    if (rst) begin
      next       = FETCH;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= br_target;
          if (is_j || is_jal) pc <= j_target;
          if (is_jr) pc <= rf[rs];
          if (is_jal && LINK != 5'd0) rf[LINK] <= pc;
        end
        EXEC: begin
          if (is_beq) begin
            if (a == b) pc <= alu_out;
          end else begin
            alu_out <= alu_res;
          end
        end
        MEM: begin
          if (mem_ready && is_lw) mdr <= mem_rdata;
        end
        WB: begin
          if (wb_dst != 5'd0) rf[wb_dst] <= wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle.
// Memory model adds 3 wait states below 0x20 and in 0x200-0x2FF.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata, pc_out;
  logic        mem_read, mem_write, instr_done, illegal;

  mips_multicycle #(.RESET_PC(32'h100), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .pc_out(pc_out), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ri(input logic [5:0] f,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jj(input logic [5:0] op,
                                     input logic [31:0] t);
    return {op, t[27:2]};
  endfunction

  function automatic int slow(input logic [31:0] ad);
    return ((ad < 32'h20) || (ad >= 32'h200 && ad < 32'h300)) ? 3 : 0;
  endfunction

  logic [31:0] mem [1024];

  task automatic put(input logic [31:0] ad, input logic [31:0] w);
    mem[ad[11:2]] = w;
  endtask

  task automatic peek(input string tag, input logic [31:0] ad,
                      input logic [31:0] exp);
    check(tag, mem[ad[11:2]], exp);
  endtask

  int cnt = 0;
  int wr_count = 0;
  int stab_checks = 0;
  int stab_err = 0;
  logic [31:0] req_addr, req_wdata;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  always begin
    @(posedge clk);
    #2;
    if (mem_read && mem_write) stab_err++;
    if (rst || !(mem_read || mem_write)) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else begin
      if (cnt == 0) begin
        req_addr  = mem_addr;
        req_wdata = mem_wdata;
      end else begin
        stab_checks++;
        if (mem_addr !== req_addr ||
            (mem_write && mem_wdata !== req_wdata)) stab_err++;
      end
      if (cnt < slow(mem_addr)) begin
        cnt++;
        mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b1;
        cnt = 0;
        if (mem_read) begin
          mem_rdata = mem[mem_addr[11:2]];
        end else begin
          mem[mem_addr[11:2]] = mem_wdata;
          wr_count++;
        end
      end
    end
  end

  int cyc = 0;
  int illegal_cnt = 0;
  logic [31:0] illegal_pc = '0;
  int lat [$];

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
    end else begin
      cyc++;
      if (instr_done) begin
        lat.push_back(cyc);
        cyc = 0;
      end
      if (illegal) begin
        illegal_cnt++;
        illegal_pc = pc_out;
      end
    end
  end

  task automatic load_prog1();
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
    put(32'h100, ii(6'h08, 0, 1, 16'd5));
    put(32'h104, ii(6'h08, 0, 2, 16'hFFFD));
    put(32'h108, ri(6'h20, 1, 2, 3));
    put(32'h10C, ri(6'h2A, 2, 1, 4));
    put(32'h110, ii(6'h08, 0, 0, 16'd7));
    put(32'h114, ii(6'h2B, 0, 3, 16'h80));
    put(32'h118, ii(6'h2B, 0, 4, 16'h84));
    put(32'h11C, ii(6'h2B, 0, 0, 16'h88));
    put(32'h120, ri(6'h22, 1, 2, 6));
    put(32'h124, ri(6'h24, 1, 2, 7));
    put(32'h128, ri(6'h25, 1, 2, 8));
    put(32'h12C, ii(6'h0A, 2, 9, 16'hFFFE));
    put(32'h130, ii(6'h2B, 0, 6, 16'h8C));
    put(32'h134, ii(6'h2B, 0, 7, 16'h90));
    put(32'h138, ii(6'h2B, 0, 8, 16'h94));
    put(32'h13C, ii(6'h2B, 0, 9, 16'h98));
    put(32'h140, jj(6'h02, 32'h200));
    put(32'h200, ii(6'h2B, 0, 3, 16'h8));
    put(32'h204, ii(6'h23, 0, 5, 16'h8));
    put(32'h208, ii(6'h2B, 0, 5, 16'h9C));
    put(32'h20C, ii(6'h04, 1, 1, 16'd2));
    put(32'h210, ii(6'h08, 0, 10, 16'd1));
    put(32'h214, ii(6'h08, 0, 10, 16'd2));
    put(32'h218, ii(6'h04, 1, 2, 16'd1));
    put(32'h21C, ii(6'h08, 0, 11, 16'd9));
    put(32'h220, jj(6'h02, 32'h40));
    put(32'h040, jj(6'h03, 32'h60));
    put(32'h044, ii(6'h2B, 0, 31, 16'hA0));
    put(32'h048, 32'hFC00_0000);
    put(32'h04C, ii(6'h2B, 0, 10, 16'hA4));
    put(32'h050, ii(6'h2B, 0, 11, 16'hA8));
    put(32'h054, ii(6'h2B, 0, 12, 16'hAC));
    put(32'h058, jj(6'h02, 32'h58));
    put(32'h060, ii(6'h08, 0, 12, 16'h33));
    put(32'h064, ri(6'h08, 31, 0, 0));
  endtask

  int wr0;
  bit found;

  initial begin
    load_prog1();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", mem_read, 0);
    check("rst_write", mem_write, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_pc", pc_out, 32'h100);
    check("rst_done", instr_done, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b0;
    #1;
    check("first_read", mem_read, 1);
    check("first_addr", mem_addr, 32'h100);
    check("first_write", mem_write, 0);

    for (int i = 0; i < 2000 && wr_count < 13; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    check("writes", wr_count, 13);
    peek("add", 32'h80, 32'd2);
    peek("slt", 32'h84, 32'd1);
    peek("r0", 32'h88, 32'd0);
    peek("sub", 32'h8C, 32'd8);
    peek("and", 32'h90, 32'd5);
    peek("or", 32'h94, 32'hFFFF_FFFD);
    peek("slti", 32'h98, 32'd1);
    peek("sw_slow", 32'h08, 32'd2);
    peek("lw_slow", 32'h9C, 32'd2);
    peek("jal_link", 32'hA0, 32'h44);
    peek("beq_taken", 32'hA4, 32'd0);
    peek("beq_fall", 32'hA8, 32'd9);
    peek("jr_ret", 32'hAC, 32'h33);
    check("lat_addi", lat[0], 4);
    check("lat_slt", lat[3], 4);
    check("lat_sw", lat[5], 4);
    check("lat_j", lat[16], 2);
    check("lat_sw_w3", lat[17], 10);
    check("lat_lw_w3", lat[18], 11);
    check("lat_beq_t", lat[20], 6);
    check("lat_beq_n", lat[21], 6);
    check("lat_jal", lat[24], 2);
    check("lat_jr", lat[26], 2);
    check("lat_illegal", lat[28], 2);
    check("illegal_cnt", illegal_cnt, 1);
    check("illegal_pc", illegal_pc, 32'h4C);
    check("stable", stab_err, 0);
    check("stable_seen", stab_checks != 0, 1);

    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
    put(32'h100, ii(6'h23, 0, 5, 16'h8));
    put(32'h104, jj(6'h02, 32'h104));
    put(32'h008, 32'h0000_1234);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mem_read && mem_addr == 32'h8) found = 1'b1;
    end
    check("lw_mem_seen", found, 1);
    wr0 = wr_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_read", mem_read, 0);
    check("mid_rst_pc", pc_out, 32'h100);
    put(32'h100, ii(6'h2B, 0, 5, 16'h80));
    put(32'h104, jj(6'h02, 32'h104));
    rst = 1'b0;
    #1;
    check("mid_read", mem_read, 1);
    check("mid_addr", mem_addr, 32'h100);
    for (int i = 0; i < 200 && wr_count == wr0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    check("mid_writes", wr_count - wr0, 1);
    peek("mid_r5", 32'h80, 32'd0);
    peek("mid_mem8", 32'h08, 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
